// File: rtl/mhsa_pkg.sv
// Definitions shared by the MHSA ICB slave and the output DMA master:
// bus widths, CSR map, DMA FSM states and the write-command payload.
package mhsa_pkg;

  localparam int unsigned ICB_AW   = 32;
  localparam int unsigned ICB_DW   = 32;
  localparam int unsigned ICB_MW   = ICB_DW / 8;
  localparam int unsigned USRAM_DW = 64;

  localparam logic [ICB_AW-1:0] CSR_START_ADDR       = 32'h0002_0000;
  localparam logic [ICB_AW-1:0] CSR_DONE_ADDR        = 32'h0002_0004;
  localparam logic [ICB_AW-1:0] CSR_INPUT_BASE_ADDR  = 32'h0002_0008;
  localparam logic [ICB_AW-1:0] CSR_OUTPUT_BASE_ADDR = 32'h0002_000C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRD,
    ST_SWAIT,
    ST_CMD_HI,
    ST_RSP_HI,
    ST_CMD_LO,
    ST_RSP_LO,
    ST_FIN
  } dma_state_e;

  typedef struct packed {
    logic [ICB_AW-1:0] addr;
    logic [ICB_DW-1:0] wdata;
  } icb_wr_cmd_t;

endpackage

// File: rtl/icb_out_dma_if.sv
// ICB command/response channel between an initiator (master) and a target (slave).
interface icb_out_dma_if
  import mhsa_pkg::*;
();

  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic              icb_cmd_read;
  logic [ICB_AW-1:0] icb_cmd_addr;
  logic [ICB_DW-1:0] icb_cmd_wdata;
  logic [ICB_MW-1:0] icb_cmd_wmask;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready;
  logic [ICB_DW-1:0] icb_rsp_rdata;
  logic              icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface

// File: rtl/icb_wr_chan.sv
// Single-beat ICB write channel: holds a command until accepted, then takes
// exactly one response and folds its error bit into a sticky flag.
module icb_wr_chan
  import mhsa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  icb_wr_cmd_t cmd,
  input  logic        err_clr,
  output logic        cmd_fire_c,
  output logic        rsp_fire_c,
  output logic        err,
  icb_out_dma_if.master icb
);

  logic              cmd_valid_q, cmd_valid_d;
  logic              rsp_ready_q, rsp_ready_d;
  logic [ICB_AW-1:0] addr_q, addr_d;
  logic [ICB_DW-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              unused_c;

  assign cmd_fire_c = cmd_valid_q & icb.icb_cmd_ready;
  assign rsp_fire_c = rsp_ready_q & icb.icb_rsp_valid;

  // Only one beat in flight: rsp_ready opens when the command is taken.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    rsp_ready_d = rsp_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    if (issue) begin
      cmd_valid_d = 1'b1;
      addr_d      = cmd.addr;
      wdata_d     = cmd.wdata;
    end
    if (cmd_fire_c) begin
      cmd_valid_d = 1'b0;
      rsp_ready_d = 1'b1;
    end
    if (rsp_fire_c) begin
      rsp_ready_d = 1'b0;
      err_d       = err_q | icb.icb_rsp_err;
    end
    if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      rsp_ready_q <= rsp_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
    end
  end

  assign icb.icb_cmd_valid = cmd_valid_q;
  assign icb.icb_cmd_read  = 1'b0;
  assign icb.icb_cmd_addr  = addr_q;
  assign icb.icb_cmd_wdata = wdata_q;
  assign icb.icb_cmd_wmask = {ICB_MW{1'b1}};
  assign icb.icb_rsp_ready = rsp_ready_q;
  assign err               = err_q;

  assign unused_c = ^icb.icb_rsp_rdata;

endmodule

// File: rtl/icb_out_dma.sv
// Output DMA: drains len 64-bit result-SRAM words to memory as pairs of
// 32-bit ICB writes, high half at the 8-byte address, low half at +4.
module icb_out_dma
  import mhsa_pkg::*;
#(
  parameter int unsigned SRAM_AW = 16,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ICB_AW-1:0]   out_base,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic                sram_rd_en,
  input  logic [USRAM_DW-1:0] sram_rdata,
  icb_out_dma_if.master       icb
);

  dma_state_e          state_q, state_d;
  logic [ICB_AW-4:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [USRAM_DW-1:0] buf_q, buf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;

  logic                accept_c;
  logic                last_c;
  logic [ICB_AW-1:0]   word_addr_c;
  logic                issue_c;
  icb_wr_cmd_t         cmd_c;
  logic                cmd_fire_c;
  logic                rsp_fire_c;
  logic                unused_c;

  // busy_q also covers the done cycle, where the FSM is already back in IDLE.
  assign accept_c    = start && (state_q == ST_IDLE) && !busy_q;
  assign last_c      = (LEN_W'(idx_q + LEN_W'(1)) == len_q);
  assign word_addr_c = {base_q, 3'b000} + (ICB_AW'(idx_q) << 3);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    issue_c  = 1'b0;
    cmd_c    = '0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (accept_c) begin
          base_d  = out_base[ICB_AW-1:3];
          len_d   = len;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = (len == '0) ? ST_FIN : ST_SRD;
        end
      end
      ST_SRD: state_d = ST_SWAIT;
      ST_SWAIT: begin
        buf_d       = sram_rdata;
        issue_c     = 1'b1;
        cmd_c.addr  = word_addr_c;
        cmd_c.wdata = sram_rdata[USRAM_DW-1:ICB_DW];
        state_d     = ST_CMD_HI;
      end
      ST_CMD_HI: if (cmd_fire_c) state_d = ST_RSP_HI;
      ST_RSP_HI: begin
        if (rsp_fire_c) begin
          issue_c     = 1'b1;
          cmd_c.addr  = word_addr_c + ICB_AW'(4);
          cmd_c.wdata = buf_q[ICB_DW-1:0];
          state_d     = ST_CMD_LO;
        end
      end
      ST_CMD_LO: if (cmd_fire_c) state_d = ST_RSP_LO;
      ST_RSP_LO: begin
        if (rsp_fire_c) begin
          if (last_c) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = ST_SRD;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // SRAM strobe and address are registered on entry to SRD.
    rd_en_d     = (state_d == ST_SRD);
    sram_addr_d = rd_en_d ? SRAM_AW'(idx_d) : sram_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  icb_wr_chan u_wr_chan (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue_c),
    .cmd        (cmd_c),
    .err_clr    (accept_c),
    .cmd_fire_c (cmd_fire_c),
    .rsp_fire_c (rsp_fire_c),
    .err        (err),
    .icb        (icb)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign sram_rd_en = rd_en_q;
  assign sram_addr  = sram_addr_q;

  // High half goes out straight from sram_rdata; low base bits are don't-care.
  assign unused_c = ^{out_base[2:0], buf_q[USRAM_DW-1:ICB_DW]};

endmodule

// File: tb/tb_icb_out_dma.sv
// Directed bench for icb_out_dma: SRAM model, ICB slave with optional stalls,
// write log compared against hand-computed addresses and data.
module tb_icb_out_dma;

  localparam int unsigned SRAM_AW = 16;
  localparam int unsigned LEN_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [31:0]        out_base;
  logic [LEN_W-1:0]   len;
  logic               busy, done, err;
  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_rd_en;
  logic [63:0]        sram_rdata;

  icb_out_dma_if icb ();

  icb_out_dma #(.SRAM_AW(SRAM_AW), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .out_base   (out_base),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sram_addr  (sram_addr),
    .sram_rd_en (sram_rd_en),
    .sram_rdata (sram_rdata),
    .icb        (icb)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [16];
  int total = 0;
  int bad   = 0;

  // Slave-side state, written only by the slave process
  logic [63:0] wlog [$];
  int          rsp_num = 0;
  int          stab_err = 0;
  int          multi_err = 0;
  int          rd_cnt = 0;
  // Knobs, written only by the main process
  bit          rnd_mode = 1'b0;
  bit          block_lo = 1'b0;
  int          err_abs  = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SRAM with one-cycle read latency plus ICB target, both updated on negedge
  initial begin : slave
    bit          pend = 1'b0;
    int          wait_cnt = 0;
    bit          stalled_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    bit          rd_prev = 1'b0;
    logic [3:0]  rd_addr_prev = '0;
    icb.icb_cmd_ready = 1'b0;
    icb.icb_rsp_valid = 1'b0;
    icb.icb_rsp_err   = 1'b0;
    icb.icb_rsp_rdata = '0;
    sram_rdata        = '0;
    forever begin
      @(negedge clk);
      sram_rdata   = rd_prev ? mem[rd_addr_prev] : 64'hBADD_F00D_BADD_F00D;
      rd_prev      = sram_rd_en;
      rd_addr_prev = sram_addr[3:0];
      if (sram_rd_en) rd_cnt++;
      if (!rst_n) begin
        pend = 1'b0; wait_cnt = 0; rd_prev = 1'b0;
        icb.icb_cmd_ready = 1'b0; icb.icb_rsp_valid = 1'b0; icb.icb_rsp_err = 1'b0;
      end else if (!pend) begin
        icb.icb_rsp_valid = 1'b0;
        icb.icb_rsp_err   = 1'b0;
        if (icb.icb_cmd_valid) begin
          if (stalled_prev && (icb.icb_cmd_addr !== prev_addr || icb.icb_cmd_wdata !== prev_wdata))
            stab_err++;
          if (block_lo && icb.icb_cmd_addr[2]) icb.icb_cmd_ready = 1'b0;
          else if (wait_cnt > 0) begin icb.icb_cmd_ready = 1'b0; wait_cnt--; end
          else icb.icb_cmd_ready = 1'b1;
        end else begin
          icb.icb_cmd_ready = 1'b0;
        end
      end else begin
        icb.icb_cmd_ready = 1'b0;
        if (icb.icb_cmd_valid) multi_err++;
        if (wait_cnt > 0) begin icb.icb_rsp_valid = 1'b0; wait_cnt--; end
        else begin icb.icb_rsp_valid = 1'b1; icb.icb_rsp_err = (rsp_num == err_abs); end
      end
      stalled_prev = icb.icb_cmd_valid && !icb.icb_cmd_ready;
      prev_addr    = icb.icb_cmd_addr;
      prev_wdata   = icb.icb_cmd_wdata;
      if (icb.icb_cmd_valid && icb.icb_cmd_ready) begin
        wlog.push_back({icb.icb_cmd_addr, icb.icb_cmd_wdata});
        pend = 1'b1;
        wait_cnt = rnd_mode ? int'($urandom_range(0, 5)) : 0;
      end else if (icb.icb_rsp_valid && icb.icb_rsp_ready) begin
        pend = 1'b0;
        rsp_num++;
        wait_cnt = rnd_mode ? int'($urandom_range(0, 5)) : 0;
      end
    end
  end

  // Start a transfer, wait for done and compare the write log to the expected stream
  task automatic run_xfer(input string tag, input logic [31:0] base, input int n,
                          input int err_rel, input bit rnd, input bit restart, input bit exp_err);
    int lbase, rdbase, sbase, mbase, cyc, dones;
    logic [31:0] a;
    lbase = wlog.size(); rdbase = rd_cnt; sbase = stab_err; mbase = multi_err;
    rnd_mode = rnd;
    err_abs  = (err_rel < 0) ? -1 : rsp_num + err_rel;
    out_base = base; len = LEN_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      start = restart && (cyc == 6);
      if (start) begin out_base = 32'h5555_0000; len = LEN_W'(7); end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(1));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    dones = 0;
    repeat (4) begin @(negedge clk); if (done) dones++; end
    chk({tag, "_extra_done"}, 64'(dones), 64'(0));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    chk({tag, "_nwrites"}, 64'(wlog.size() - lbase), 64'(2 * n));
    for (int k = 0; k < n && (lbase + 2 * k + 1) < wlog.size(); k++) begin
      a = (base & 32'hFFFF_FFF8) + 32'(8 * k);
      chk($sformatf("%s_w%0d_hi", tag, k), wlog[lbase + 2 * k], {a, mem[k % 16][63:32]});
      chk($sformatf("%s_w%0d_lo", tag, k), wlog[lbase + 2 * k + 1], {a + 32'd4, mem[k % 16][31:0]});
    end
    chk({tag, "_sram_reads"}, 64'(rd_cnt - rdbase), 64'(n));
    chk({tag, "_hold_stable"}, 64'(stab_err - sbase), 64'(0));
    chk({tag, "_one_outstanding"}, 64'(multi_err - mbase), 64'(0));
  endtask

  initial begin : main
    int lbase, rdbase, cyc;
    rst_n = 1'b0; start = 1'b0; out_base = '0; len = '0;
    mem[0] = 64'h1111_2222_3333_4444;
    mem[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    mem[2] = 64'h0123_4567_89AB_CDEF;
    mem[3] = 64'hFEDC_BA98_7654_3210;
    for (int k = 4; k < 16; k++) mem[k] = {32'(k) * 32'h0101_0101, ~(32'(k) * 32'h0101_0101)};
    repeat (3) @(negedge clk);

    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_cmd_valid", 64'(icb.icb_cmd_valid), 64'(0));
    chk("rst_rsp_ready", 64'(icb.icb_rsp_ready), 64'(0));
    chk("rst_rd_en", 64'(sram_rd_en), 64'(0));
    chk("rst_sram_addr", 64'(sram_addr), 64'(0));
    chk("rst_cmd_addr", 64'(icb.icb_cmd_addr), 64'(0));
    chk("rst_cmd_wdata", 64'(icb.icb_cmd_wdata), 64'(0));
    chk("const_read", 64'(icb.icb_cmd_read), 64'(0));
    chk("const_wmask", 64'(icb.icb_cmd_wmask), 64'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic zero-wait run, checked against the literal write list too
    lbase = wlog.size();
    run_xfer("basic", 32'h8000_0000, 2, -1, 1'b0, 1'b0, 1'b0);
    if (wlog.size() >= lbase + 4) begin
      chk("basic_lit0", wlog[lbase + 0], 64'h8000_0000_1111_2222);
      chk("basic_lit1", wlog[lbase + 1], 64'h8000_0004_3333_4444);
      chk("basic_lit2", wlog[lbase + 2], 64'h8000_0008_AAAA_BBBB);
      chk("basic_lit3", wlog[lbase + 3], 64'h8000_000C_CCCC_DDDD);
    end else begin
      chk("basic_lit_count", 64'(wlog.size() - lbase), 64'(4));
    end

    // Random stalls; low base bits must be ignored
    run_xfer("bp", 32'h0000_1003, 4, -1, 1'b1, 1'b0, 1'b0);

    // len == 0: done two cycles after start, no traffic
    lbase = wlog.size(); rdbase = rd_cnt;
    out_base = 32'h0000_1234; len = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("len0_done_c1", 64'(done), 64'(0));
    chk("len0_busy_c1", 64'(busy), 64'(1));
    @(negedge clk);
    chk("len0_done_c2", 64'(done), 64'(1));
    @(negedge clk);
    chk("len0_done_c3", 64'(done), 64'(0));
    chk("len0_busy_c3", 64'(busy), 64'(0));
    chk("len0_writes", 64'(wlog.size() - lbase), 64'(0));
    chk("len0_reads", 64'(rd_cnt - rdbase), 64'(0));

    // Error on third response: run completes, err sticks until next start
    run_xfer("err", 32'h4000_0000, 2, 2, 1'b0, 1'b0, 1'b1);
    chk("err_sticky_idle", 64'(err), 64'(1));
    out_base = '0; len = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("err_cleared", 64'(err), 64'(0));
    repeat (3) @(negedge clk);

    // Start pulsed mid-transfer is ignored
    run_xfer("restart", 32'h1000_0000, 3, -1, 1'b0, 1'b1, 1'b0);

    // 32-bit address wrap
    lbase = wlog.size();
    run_xfer("wrap", 32'hFFFF_FFF8, 2, -1, 1'b0, 1'b0, 1'b0);
    if (wlog.size() >= lbase + 4) begin
      chk("wrap_lit2", wlog[lbase + 2], 64'h0000_0000_AAAA_BBBB);
      chk("wrap_lit3", wlog[lbase + 3], 64'h0000_0004_CCCC_DDDD);
    end

    // Async reset while the low-half command is held
    block_lo = 1'b1;
    out_base = 32'h0000_0100; len = LEN_W'(1); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(icb.icb_cmd_valid && icb.icb_cmd_addr[2]) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("rst_mid_reach_lo", 64'(icb.icb_cmd_valid && icb.icb_cmd_addr[2]), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(icb.icb_cmd_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_rsp_ready", 64'(icb.icb_rsp_ready), 64'(0));
    repeat (2) @(negedge clk);
    block_lo = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle_busy", 64'(busy), 64'(0));
    chk("rst_mid_idle_valid", 64'(icb.icb_cmd_valid), 64'(0));
    run_xfer("post_rst", 32'h0000_2000, 1, -1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icb_out_dma.md
Name: icb_out_dma

Overview:
ICB initiator that drains N 64-bit words from the accelerator's result SRAM into system memory, starting at a programmed output base address. Each SRAM word becomes two 32-bit ICB writes. The high half goes first, at the 8-byte-aligned address; the low half goes at +4. This matches the 32/64-bit lane order used by the MHSA ICB slave's usram merge. Sits beside the slave interface unit; it is kicked by the CSR start and reports completion back to the CSR done register.

Parameters:
SRAM_AW, 16, result SRAM word-address width
LEN_W, 16, width of the transfer length (in 64-bit words)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle kick; sampled only in IDLE
out_base  in  32  byte address of first destination word; bits [2:0] ignored (treated as 0)
len  in  LEN_W  number of 64-bit words to transfer
busy  out  1  high from accepted start until done pulse, inclusive
done  out  1  one-cycle pulse at completion
err  out  1  sticky: set if any response had icb_rsp_err=1; cleared on accepted start
sram_addr  out  SRAM_AW  result SRAM read address (word index)
sram_rd_en  out  1  read strobe; data valid on sram_rdata the next cycle
sram_rdata  in  64  result SRAM read data
icb_cmd_valid  out  1  command valid
icb_cmd_ready  in  1  command ready
icb_cmd_read  out  1  constant 0 (write-only master)
icb_cmd_addr  out  32  byte address
icb_cmd_wdata  out  32  write data
icb_cmd_wmask  out  4  constant 4'hF
icb_rsp_valid  in  1  response valid
icb_rsp_ready  out  1  response ready
icb_rsp_rdata  in  32  ignored
icb_rsp_err  in  1  response error

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, sram_rd_en, icb_cmd_valid, icb_rsp_ready = 0; icb_cmd_addr, icb_cmd_wdata, sram_addr = 0; word counter and data buffer = 0. Reset mid-transfer abandons the transfer immediately with no further cmd.
- FSM states: IDLE, SRD, SWAIT, CMD_HI, RSP_HI, CMD_LO, RSP_LO, FIN.
- IDLE: on start=1, latch out_base[31:3], len, and word index i=0; clear err; busy=1. If len==0, go to FIN; otherwise go to SRD.
- SRD: sram_rd_en=1 for one cycle, sram_addr=i; go to SWAIT.
- SWAIT: capture sram_rdata into a 64-bit buffer; go to CMD_HI.
- CMD_HI: icb_cmd_valid=1, addr = base + 8*i, wdata = buf[63:32]. Hold addr, wdata and valid stable until icb_cmd_valid & icb_cmd_ready. Then drop valid the next cycle and go to RSP_HI.
- RSP_HI: icb_rsp_ready=1; on icb_rsp_valid, OR icb_rsp_err into err and go to CMD_LO.
- CMD_LO/RSP_LO: same handshake with addr = base + 8*i + 4 and wdata = buf[31:0]. On the response: if i==len-1, go to FIN; else i=i+1 and go to SRD.
- Exactly one outstanding ICB transaction at any time. No new cmd is issued before the previous rsp is accepted.
- FIN: done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE.
- start while busy: ignored, with no effect on latched parameters.
- Address arithmetic: 32-bit, wraps modulo 2^32 (0xFFFFFFF8 + 8 → 0x0).
- sram_addr = i truncated to SRAM_AW. len larger than 2^SRAM_AW wraps the SRAM index; this is not an error.
- Response error does not abort: the transfer completes and err stays set until the next accepted start.
- Minimum per-word latency with zero-wait slave (ready and rsp in the cycle after valid): 8 cycles.

Decomposition:
- Shared package mhsa_pkg: FSM state enum, ICB_AW=32, ICB_DW=32, USRAM_DW=64, and the CSR address constants (START 0x20000, DONE 0x20004, INPUT_BASE 0x20008, OUTPUT_BASE 0x2000C), so slave and master share one definition.
- One natural sub-module: icb_wr_chan, covering single-beat cmd/rsp handshake with hold-while-not-ready and error capture. It is instantiated once and sequenced for the HI/LO halves.

Test Plan:
- Basic: base=0x8000_0000, len=2, SRAM[0]=0x1111_2222_3333_4444, SRAM[1]=0xAAAA_BBBB_CCCC_DDDD, zero-wait slave → writes (0x80000000,0x11112222), (0x80000004,0x33334444), (0x80000008,0xAAAABBBB), (0x8000000C,0xCCCCDDDD) in order; one done pulse; err=0.
- Backpressure: random icb_cmd_ready/icb_rsp_valid stalls of 0-5 cycles, len=4 → addr/wdata stable while valid & !ready; never two cmds before a rsp; same 8 writes as the unstalled run.
- len=0 with start → no ICB cmd, no sram_rd_en; done pulses 2 cycles after start.
- Error: icb_rsp_err=1 on the 3rd response of len=2 → all 4 writes still issued; err=1 after done; next start clears err to 0.
- start pulsed again mid-transfer with different base → ignored; addresses continue from the original base. Address wrap: base=0xFFFF_FFF8, len=2 → second word written at 0x0 and 0x4.
- rst_n asserted during CMD_LO → icb_cmd_valid drops to 0 without waiting for a clock edge; after release, state is IDLE, busy=0, and a new start runs normally.
